// File: rtl/piso_buf_256b.sv
// 256-byte parallel-in / serial-out buffer: 64 x 32-bit words loaded one at a time,
// then streamed out as 2048 contiguous bits, word 0 first, LSB first.
module piso_buf_256b (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pin,
  output logic        sout,
  input  logic        val_op,
  input  logic        op,
  output logic        scaning,
  output logic        op_ack,
  output logic        op_commit
);

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = 5;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DW - 1);
  localparam logic [AW-1:0] RPTR_LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LACK  = 3'd1,
    FETCH = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [DW-1:0]   sreg;
  logic [CW-1:0]   cnt;
  logic            last_shift;

  logic            word_end;
  assign word_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (val_op) state_nx = op ? FETCH : LACK;
      LACK:    state_nx = DONE;
      FETCH:   state_nx = SHIFT;
      SHIFT:   if (word_end && (rptr == RPTR_LAST)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    op_ack    = (state == LACK) || (state == FETCH);
    op_commit = (state == DONE);
    scaning   = (state == SHIFT);
    sout      = (state == SHIFT) && sreg[0];
  end

  // Storage, pointers and shifter; the next word is loaded on the last bit so the stream has no gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr       <= '0;
      rptr       <= '0;
      sreg       <= '0;
      cnt        <= '0;
      last_shift <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (val_op) begin
            if (!op) begin
              mem[wptr]  <= pin;
              wptr       <= wptr + AW'(1);
              last_shift <= 1'b0;
            end else begin
              rptr       <= '0;
              last_shift <= 1'b1;
            end
          end
        end
        FETCH: begin
          sreg <= mem[0];
          cnt  <= '0;
        end
        SHIFT: begin
          if (word_end && (rptr != RPTR_LAST)) begin
            sreg <= mem[rptr + AW'(1)];
            rptr <= rptr + AW'(1);
            cnt  <= '0;
          end else begin
            sreg <= sreg >> 1;
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (last_shift) wptr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_buf_256b.sv
// Directed bench for piso_buf_256b: table-driven LOAD vectors plus full SHIFT stream captures.
module tb_piso_buf_256b;

  logic        clk;
  logic        reset;
  logic [31:0] pin;
  logic        sout;
  logic        val_op;
  logic        op;
  logic        scaning;
  logic        op_ack;
  logic        op_commit;

  int nvec;
  int nmis;

  logic [31:0] mdl [64];
  logic [31:0] cap [64];

  typedef struct {
    logic        val_op;
    logic        op;
    logic [31:0] pin;
    logic [3:0]  exp;   // {op_ack, op_commit, scaning, sout}
  } vec_t;

  vec_t vecs [12];

  piso_buf_256b dut (
    .clk       (clk),
    .reset     (reset),
    .pin       (pin),
    .sout      (sout),
    .val_op    (val_op),
    .op        (op),
    .scaning   (scaning),
    .op_ack    (op_ack),
    .op_commit (op_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] exp);
    check(name, {28'b0, op_ack, op_commit, scaning, sout}, {28'b0, exp});
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      val_op = vecs[k].val_op;
      op     = vecs[k].op;
      pin    = vecs[k].pin;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", k), vecs[k].exp);
    end
  endtask

  task automatic load_word(input logic [31:0] v);
    val_op = 1'b1; op = 1'b0; pin = v;
    @(posedge clk); #1;
    check_outs("load_ack", 4'b1000);
    val_op = 1'b0; pin = 32'h0;
    @(posedge clk); #1;
    check_outs("load_commit", 4'b0100);
    @(posedge clk); #1;
    check_outs("load_idle", 4'b0000);
  endtask

  // Issues a SHIFT from IDLE, captures the stream into cap[]; abort_at>=0 asserts reset after that bit
  task automatic run_shift(input string tag, input int abort_at, input bit toggle);
    int scan_bad;
    int commits;
    val_op = 1'b1; op = 1'b1;
    @(posedge clk); #1;
    check_outs({tag, "_fetch"}, 4'b1000);
    val_op = 1'b0; op = 1'b0;
    scan_bad = 0;
    commits  = 0;
    for (int i = 0; i < 2048; i++) begin
      if (toggle) begin
        val_op = 1'($urandom);
        op     = 1'($urandom);
        pin    = $urandom;
      end
      @(posedge clk); #1;
      if (scaning !== 1'b1 || op_ack !== 1'b0) scan_bad++;
      if (op_commit !== 1'b0) commits++;
      cap[6'(i >> 5)][5'(i)] = sout;
      if (i == abort_at) begin
        #2 reset = 1'b1;
        #1 check_outs({tag, "_abort_now"}, 4'b0000);
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          check_outs({tag, "_abort_hold"}, 4'b0000);
        end
        @(negedge clk);
        reset = 1'b0; val_op = 1'b0; op = 1'b0;
        return;
      end
    end
    val_op = 1'b0; op = 1'b0;
    check({tag, "_scan_window"}, 32'(scan_bad), 32'd0);
    check({tag, "_early_commit"}, 32'(commits), 32'd0);
    @(posedge clk); #1;
    check_outs({tag, "_done"}, 4'b0100);
    @(posedge clk); #1;
    check_outs({tag, "_idle"}, 4'b0000);
    for (int w = 0; w < 64; w++)
      check($sformatf("%s_word%0d", tag, w), cap[w], mdl[w]);
  endtask

  initial begin
    int ones;
    nvec = 0;
    nmis = 0;
    for (int w = 0; w < 64; w++) mdl[w] = 32'h0;

    // LOAD 1, then LOAD 0x80000000 with val_op held through LACK (ignored there)
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0001, 4'b1000};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 4'b0100};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 4'b0000};
    vecs[3]  = '{1'b1, 1'b0, 32'h8000_0000, 4'b1000};
    vecs[4]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 4'b0100};
    vecs[5]  = '{1'b0, 1'b0, 32'h1234_5678, 4'b0000};
    // val_op held high with op=0: accept, LACK, DONE repeating every 3 cycles
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_000A, 4'b1000};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_000B, 4'b0100};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_000C, 4'b0000};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_000D, 4'b1000};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_000E, 4'b0100};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_000F, 4'b0000};

    reset = 1'b1; val_op = 1'b0; op = 1'b0; pin = 32'h0;
    #1 check_outs("reset", 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Empty buffer streams 2048 zeros
    run_shift("empty", -1, 1'b0);

    apply_vecs(0, 5);
    mdl[0] = 32'h0000_0001;
    mdl[1] = 32'h8000_0000;
    run_shift("two", -1, 1'b0);
    ones = 0;
    for (int w = 0; w < 64; w++) ones += $countones(cap[w]);
    check("two_bit0", 32'(cap[0][0]), 32'd1);
    check("two_bit63", 32'(cap[1][31]), 32'd1);
    check("two_popcount", 32'(ones), 32'd2);

    // wptr was cleared by the SHIFT commit, so these land in words 0 and 1
    apply_vecs(6, 11);
    mdl[0] = 32'h0000_000A;
    mdl[1] = 32'h0000_000D;
    run_shift("toggle", -1, 1'b1);
    run_shift("reshift", -1, 1'b0);

    for (int k = 1; k <= 65; k++) begin
      load_word(32'(k));
      mdl[(k - 1) % 64] = 32'(k);
    end
    run_shift("wrap", -1, 1'b0);
    check("wrap_word0", cap[0], 32'd65);
    check("wrap_word1", cap[1], 32'd2);
    check("wrap_word63", cap[63], 32'd64);

    run_shift("abort", 1000, 1'b0);
    for (int w = 0; w < 64; w++) mdl[w] = 32'h0;
    run_shift("post_abort", -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
